bch_syndrome_ctrl: RTL and testbench

Sequencer for the BCH syndrome datapath (array of `dsynN_method2` instances). Accepts a stream of codeword beats over a valid/ready handshake and drives the shared `ce`/`start`/`start_pipelined`/data/data_pipelined bus. Tracks each codeword's final beat through the datapath pipeline, then captures the completed syndrome bus into an output register with its own valid/ready handshake. Sits between the input framer and the error-locator stage.

---
 rtl/bch_syn_ctrl_pkg.sv | 26 ++
 rtl/bch_syndrome_ctrl_pipeline_ce.sv | 28 ++
 rtl/bch_syndrome_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bch_syndrome_ctrl.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_syn_ctrl_pkg.sv
// ============================================================================
// Package : bch_syn_ctrl_pkg
// Brief   : Shared state encoding and sizing helpers for the BCH syndrome
//           sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bch_syn_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_STALL = 2'd3;

    function automatic int beats(input int n, input int bits);
        return (n + bits - 1) / bits;
    endfunction

    function automatic int bcnt_w(input int nbeats);
        return (nbeats <= 1) ? 1 : $clog2(nbeats);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bch_syndrome_ctrl_pipeline_ce.sv
// ============================================================================
// Module  : pipeline_ce
// Brief   : Clock-enabled delay register matching one datapath ce step.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pipeline_ce #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bch_syndrome_ctrl.sv
// ============================================================================
// Module  : bch_syndrome_ctrl
// Brief   : Beat sequencer and syndrome capture for the BCH syndrome datapath.
//           Optional framing check: define BCH_SYN_CTRL_FRAME_CHECK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module bch_syndrome_ctrl
    import bch_syn_ctrl_pkg::*;
#(
    parameter int N               = 15,
    parameter int BITS            = 4,
    parameter int PIPELINE_STAGES = 0,
    parameter int SYN_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_last,
    output logic             syn_ce,
    output logic             syn_start,
    output logic             syn_start_pipelined,
    output logic [BITS-1:0]  syn_data,
    output logic [BITS-1:0]  syn_data_pipelined,
    input  logic [SYN_W-1:0] syn_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYN_W-1:0] out_syn,
    output logic             frame_err
);

    localparam int                BEATS     = beats(N, BITS);
    localparam int                CNT_W     = bcnt_w(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam int                LM_W      = (PIPELINE_STAGES > 0) ? PIPELINE_STAGES : 1;

    logic             run;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] bcnt_nxt;
    logic [LM_W-1:0]  lmark;
    logic [1:0]       state;
    logic             at_last;
    logic             frame_ok;
    logic             mark_ok;
    logic             land_due;
    logic             landed;
    logic             accept;
    logic             bubble;
    logic             set_mark;
    logic             lm_busy;

    assign at_last = (bcnt == LAST_BEAT);
    assign lm_busy = |lmark;
    assign mark_ok = in_valid & at_last & frame_ok;

    generate
        if (PIPELINE_STAGES == 0) begin : g_land_direct
            assign land_due = mark_ok;
        end else begin : g_land_marker
            assign land_due = lmark[LM_W-1];
        end
    endgenerate

    // A capture that cannot be stored freezes ce, holding the whole datapath.
    always_comb begin
        state = ST_RUN;
        if (land_due && out_valid && !out_ready) begin
            state = ST_STALL;
        end else if (lm_busy && !in_valid) begin
            state = ST_DRAIN;
        end else if (!lm_busy && (bcnt == '0)) begin
            state = ST_IDLE;
        end
    end

    assign in_ready  = run & (state != ST_STALL);
    assign accept    = in_valid & in_ready;
    assign bubble    = (state == ST_DRAIN);
    assign syn_ce    = accept | bubble;
    assign syn_start = accept & (bcnt == '0);
    assign syn_data  = accept ? in_data : '0;
    assign landed    = syn_ce & land_due;
    assign set_mark  = accept & mark_ok;

    generate
        if (PIPELINE_STAGES == 0) begin : g_lmark_none
            assign lmark = '0;
        end else if (PIPELINE_STAGES == 1) begin : g_lmark_one
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lmark <= '0;
                end else if (syn_ce) begin
                    lmark <= set_mark;
                end
            end
        end else begin : g_lmark_shift
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lmark <= '0;
                end else if (syn_ce) begin
                    lmark <= {lmark[LM_W-2:0], set_mark};
                end
            end
        end
    endgenerate

`ifdef BCH_SYN_CTRL_FRAME_CHECK_EN
    logic bad;
    logic ferr;

    assign frame_ok  = in_last & ~bad;
    assign frame_err = ferr;

    always_comb begin
        bcnt_nxt = bcnt + CNT_ONE;
        if (in_last || at_last) begin
            bcnt_nxt = '0;
        end
    end

    // A codeword missing its in_last stays poisoned until one is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad  <= 1'b0;
            ferr <= 1'b0;
        end else if (accept) begin
            if (in_last != at_last) begin
                ferr <= 1'b1;
            end
            if (in_last) begin
                bad <= 1'b0;
            end else if (at_last) begin
                bad <= 1'b1;
            end
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign frame_ok       = 1'b1;
    assign frame_err      = 1'b0;

    always_comb begin
        bcnt_nxt = bcnt + CNT_ONE;
        if (at_last) begin
            bcnt_nxt = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run  <= 1'b0;
            bcnt <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                bcnt <= bcnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_syn   <= '0;
        end else if (landed) begin
            out_valid <= 1'b1;
            out_syn   <= syn_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    generate
        if (PIPELINE_STAGES == 0) begin : g_data_pass
            assign syn_data_pipelined = syn_data;
        end else begin : g_data_dly
            pipeline_ce #(.WIDTH(BITS)) u_data_dly (
                .clk     (clk),
                .reset_n (reset_n),
                .ce      (syn_ce),
                .d       (syn_data),
                .q       (syn_data_pipelined)
            );
        end

        if (PIPELINE_STAGES < 2) begin : g_start_pass
            assign syn_start_pipelined = syn_start;
        end else begin : g_start_dly
            pipeline_ce #(.WIDTH(1)) u_start_dly (
                .clk     (clk),
                .reset_n (reset_n),
                .ce      (syn_ce),
                .d       (syn_start),
                .q       (syn_start_pipelined)
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bch_syndrome_ctrl.sv
// ============================================================================
// Module  : tb_bch_syndrome_ctrl
// Brief   : Self-checking bench; instance 0 has no datapath pipeline,
//           instance 1 has two stages. Honours BCH_SYN_CTRL_FRAME_CHECK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_bch_syndrome_ctrl;

    localparam int N     = 15;
    localparam int BITS  = 4;
    localparam int SYN_W = 8;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [1:0]       in_valid, in_last, out_ready;
    logic [1:0]       in_ready, syn_ce, syn_start, syn_start_pipelined, out_valid, frame_err;
    logic [BITS-1:0]  in_data [2];
    logic [BITS-1:0]  syn_data [2];
    logic [BITS-1:0]  syn_data_pipelined [2];
    logic [SYN_W-1:0] syn_in [2];
    logic [SYN_W-1:0] out_syn [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt [2];
    int last_acc [2];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        syn_in[0] = '0;
        syn_in[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            syn_in[0] = SYN_W'($urandom);
            syn_in[1] = SYN_W'($urandom);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int PS = 2 * g;

        bch_syndrome_ctrl #(
            .N(N), .BITS(BITS), .PIPELINE_STAGES(PS), .SYN_W(SYN_W)
        ) u_dut (
            .clk                 (clk),
            .reset_n             (reset_n),
            .in_valid            (in_valid[g]),
            .in_ready            (in_ready[g]),
            .in_data             (in_data[g]),
            .in_last             (in_last[g]),
            .syn_ce              (syn_ce[g]),
            .syn_start           (syn_start[g]),
            .syn_start_pipelined (syn_start_pipelined[g]),
            .syn_data            (syn_data[g]),
            .syn_data_pipelined  (syn_data_pipelined[g]),
            .syn_in              (syn_in[g]),
            .out_valid           (out_valid[g]),
            .out_ready           (out_ready[g]),
            .out_syn             (out_syn[g]),
            .frame_err           (frame_err[g])
        );

        // Reference model: beat position within the codeword, and for each
        // final beat still in flight, how many datapath ce steps remain.
        int               idx;
        int               pend [$];
        bit               ev, run_m, ferr_m, bad_m, sp;
        logic [SYN_W-1:0] es;
        logic [BITS-1:0]  dp;

        always @(negedge clk) begin : mon
            bit              due, stl, rdy, acc, bub, ce, st, lastb, fok, lnd;
            logic [BITS-1:0] d, edp;
            bit              esp;
            if (!reset_n) begin
                idx = 0; pend.delete(); ev = 0; es = '0; run_m = 0;
                ferr_m = 0; bad_m = 0; dp = '0; sp = 0;
                checks++;
                if ({in_ready[g], syn_ce[g], syn_start[g], syn_start_pipelined[g], out_valid[g], frame_err[g]} !== 6'b0
                    || syn_data[g] !== '0 || syn_data_pipelined[g] !== '0 || out_syn[g] !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs inst%0d: rdy/ce/st/stp/ov/fe=%b%b%b%b%b%b data=%h dp=%h syn=%h required all 0",
                             g, in_ready[g], syn_ce[g], syn_start[g], syn_start_pipelined[g], out_valid[g], frame_err[g],
                             syn_data[g], syn_data_pipelined[g], out_syn[g]);
                end
            end else begin
                fok = 1;
`ifdef BCH_SYN_CTRL_FRAME_CHECK_EN
                fok = in_last[g] && !bad_m;
`endif
                lastb = in_valid[g] && (idx == BEATS - 1) && fok;
                if (PS == 0) due = lastb;
                else         due = (pend.size() > 0) && (pend[0] == 1);
                stl = due && ev && !out_ready[g];
                rdy = run_m && !stl;
                acc = in_valid[g] && rdy;
                bub = (pend.size() > 0) && !in_valid[g] && !stl;
                ce  = acc || bub;
                st  = acc && (idx == 0);
                d   = acc ? in_data[g] : '0;
                lnd = ce && due;
                edp = (PS == 0) ? d : dp;
                esp = (PS < 2) ? st : sp;

                checks++;
                if ({in_ready[g], syn_ce[g], syn_start[g]} !== {rdy, ce, st} || syn_data[g] !== d) begin
                    errors++;
                    $display("FAIL bus inst%0d cyc%0d: rdy/ce/start=%b%b%b data=%h required %b%b%b data=%h",
                             g, cyc, in_ready[g], syn_ce[g], syn_start[g], syn_data[g], rdy, ce, st, d);
                end
                checks++;
                if (syn_data_pipelined[g] !== edp || syn_start_pipelined[g] !== esp) begin
                    errors++;
                    $display("FAIL pipelined inst%0d cyc%0d: data_p=%h start_p=%b required %h %b",
                             g, cyc, syn_data_pipelined[g], syn_start_pipelined[g], edp, esp);
                end
                checks++;
                if (out_valid[g] !== ev || out_syn[g] !== es) begin
                    errors++;
                    $display("FAIL capture inst%0d cyc%0d: out_valid=%b out_syn=%h required %b %h",
                             g, cyc, out_valid[g], out_syn[g], ev, es);
                end
                checks++;
                if (frame_err[g] !== ferr_m) begin
                    errors++;
                    $display("FAIL frame_err inst%0d cyc%0d: got %b required %b", g, cyc, frame_err[g], ferr_m);
                end

                if (ce) begin
                    dp = d;
                    sp = st;
                    if (PS > 0) begin
                        if (pend.size() > 0 && pend[0] == 1) void'(pend.pop_front());
                        foreach (pend[i]) pend[i] = pend[i] - 1;
                        if (acc && lastb) pend.push_back(PS);
                    end
                end
                if (lnd) begin
                    ev = 1;
                    es = syn_in[g];
                end else if (out_ready[g]) begin
                    ev = 0;
                end
                if (acc) begin
`ifdef BCH_SYN_CTRL_FRAME_CHECK_EN
                    if ((in_last[g] == 1'b1) != (idx == BEATS - 1)) ferr_m = 1;
                    if (in_last[g]) bad_m = 0;
                    else if (idx == BEATS - 1) bad_m = 1;
                    idx = (in_last[g] || idx == BEATS - 1) ? 0 : idx + 1;
`else
                    idx = (idx + 1) % BEATS;
`endif
                end
                run_m = 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input int g, input bit last);
        int n = 0;
        in_valid[g] = 1'b1;
        in_data[g]  = BITS'($urandom);
        in_last[g]  = last;
        @(negedge clk);
        while (in_ready[g] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout inst%0d: in_ready=%b required 1", g, in_ready[g]);
        end else begin
            acc_cnt[g]++;
            last_acc[g] = cyc;
        end
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        in_last[g]  = 1'b0;
    endtask

    task automatic send_cw(input int g, input int maxgap);
        for (int b = 0; b < BEATS; b++) begin
            drive_beat(g, b == BEATS - 1);
            if (b < BEATS - 1) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic count_valid(input int g, input int n, output int seen, output int at);
        seen = 0;
        at   = -1;
        repeat (n) begin
            @(negedge clk);
            if (out_valid[g] === 1'b1) begin
                seen++;
                if (at < 0) at = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 2'b11;
        idle(3);
        checks++;
        if (in_ready !== 2'b00 || out_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b required 00 00", in_ready, out_valid);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL ready_after_release: in_ready=%b required 00", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 2'b11) begin
            errors++;
            $display("FAIL ready_one_cycle_later: in_ready=%b required 11", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single(input int g);
        int seen, at, bub;
        out_ready[g] = 1'b1;
        send_cw(g, 2);
        seen = 0; at = -1; bub = 0;
        repeat (8) begin
            @(negedge clk);
            if (syn_ce[g] === 1'b1 && in_valid[g] === 1'b0) begin
                bub++;
                checks++;
                if (syn_data[g] !== '0 || syn_start[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_data inst%0d: data=%h start=%b required 0 0", g, syn_data[g], syn_start[g]);
                end
            end
            if (out_valid[g] === 1'b1) begin
                seen++;
                if (at < 0) at = cyc;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (seen != 1 || at != last_acc[g] + 1 + 2 * g) begin
            errors++;
            $display("FAIL single_latency inst%0d: pulses=%0d at=%0d required 1 at %0d", g, seen, at, last_acc[g] + 1 + 2 * g);
        end
        checks++;
        if (bub != 2 * g) begin
            errors++;
            $display("FAIL bubble_count inst%0d: got %0d required %0d", g, bub, 2 * g);
        end
    endtask

    task automatic test_back_to_back(input int g);
        int q [$];
        int f = 0;
        out_ready[g] = 1'b1;
        fork
            begin
                for (int b = 0; b < 3 * BEATS; b++) begin
                    drive_beat(g, (b % BEATS) == BEATS - 1);
                    if (b == 0) f = last_acc[g];
                end
            end
            begin
                repeat (3 * BEATS + 8) begin
                    @(negedge clk);
                    if (out_valid[g] === 1'b1) q.push_back(cyc);
                end
            end
        join
        idle(1);
        checks++;
        if (last_acc[g] - f != 3 * BEATS - 1) begin
            errors++;
            $display("FAIL b2b_accepts inst%0d: span=%0d required %0d", g, last_acc[g] - f, 3 * BEATS - 1);
        end
        checks++;
        if (q.size() != 3) begin
            errors++;
            $display("FAIL b2b_pulses inst%0d: got %0d required 3", g, q.size());
        end else if (q[0] != f + BEATS + 2 * g || q[1] - q[0] != BEATS || q[2] - q[1] != BEATS) begin
            errors++;
            $display("FAIL b2b_spacing inst%0d: at %0d %0d %0d required %0d then every %0d",
                     g, q[0], q[1], q[2], f + BEATS + 2 * g, BEATS);
        end
    endtask

    task automatic test_stall(input int g);
        logic [SYN_W-1:0] r1, s2;
        int n = 0;
        int a0;
        out_ready[g] = 1'b0;
        send_cw(g, 1);
        @(negedge clk);
        while (out_valid[g] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        r1 = out_syn[g];
        @(posedge clk);
        #1;
        a0 = acc_cnt[g];
        fork
            send_cw(g, 1);
            begin
                n = 0;
                @(negedge clk);
                while (in_ready[g] !== 1'b0 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 100 || syn_ce[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_entry inst%0d: in_ready=%b syn_ce=%b required 0 0", g, in_ready[g], syn_ce[g]);
                end
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready[g] !== 1'b0 || out_valid[g] !== 1'b1 || out_syn[g] !== r1) begin
                        errors++;
                        $display("FAIL stall_hold inst%0d: rdy=%b ov=%b syn=%h required 0 1 %h",
                                 g, in_ready[g], out_valid[g], out_syn[g], r1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready[g] = 1'b1;
                @(negedge clk);
                s2 = syn_in[g];
                @(negedge clk);
                checks++;
                if (out_valid[g] !== 1'b1 || out_syn[g] !== s2) begin
                    errors++;
                    $display("FAIL stall_release inst%0d: ov=%b syn=%h required 1 %h", g, out_valid[g], out_syn[g], s2);
                end
            end
        join
        idle(4);
        checks++;
        if (acc_cnt[g] - a0 != BEATS) begin
            errors++;
            $display("FAIL stall_beats inst%0d: accepted %0d required %0d", g, acc_cnt[g] - a0, BEATS);
        end
    endtask

    task automatic test_reset_mid;
        int seen, at;
        out_ready = 2'b11;
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 3; b++) drive_beat(g, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, syn_ce, syn_start, out_valid, frame_err} !== 10'b0 || out_syn[0] !== '0 || out_syn[1] !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rdy=%b ce=%b st=%b ov=%b fe=%b required all 0",
                     in_ready, syn_ce, syn_start, out_valid, frame_err);
        end
        idle(2);
        reset_n = 1'b1;
        idle(1);
        for (int g = 0; g < 2; g++) begin
            send_cw(g, 1);
            count_valid(g, 6, seen, at);
            checks++;
            if (seen != 1 || at != last_acc[g] + 1 + 2 * g) begin
                errors++;
                $display("FAIL reset_mid_recover inst%0d: pulses=%0d at=%0d required 1 at %0d",
                         g, seen, at, last_acc[g] + 1 + 2 * g);
            end
        end
    endtask

    task automatic test_frame(input int g);
        int seen, at;
        out_ready[g] = 1'b1;
`ifdef BCH_SYN_CTRL_FRAME_CHECK_EN
        drive_beat(g, 1'b0);
        drive_beat(g, 1'b0);
        drive_beat(g, 1'b1);
        count_valid(g, 6, seen, at);
        checks++;
        if (seen != 0 || frame_err[g] !== 1'b1) begin
            errors++;
            $display("FAIL frame_short inst%0d: pulses=%0d frame_err=%b required 0 1", g, seen, frame_err[g]);
        end
        send_cw(g, 1);
        count_valid(g, 6, seen, at);
        checks++;
        if (seen != 1 || frame_err[g] !== 1'b1) begin
            errors++;
            $display("FAIL frame_recover inst%0d: pulses=%0d frame_err=%b required 1 1", g, seen, frame_err[g]);
        end
`else
        for (int b = 0; b < BEATS; b++) drive_beat(g, 1'($urandom));
        count_valid(g, 6, seen, at);
        checks++;
        if (seen != 1 || frame_err[g] !== 1'b0) begin
            errors++;
            $display("FAIL last_ignored inst%0d: pulses=%0d frame_err=%b required 1 0", g, seen, frame_err[g]);
        end
`endif
    endtask

    task automatic test_random;
        int done = 0;
        fork
            begin
                for (int k = 0; k < 25; k++) send_cw(0, 3);
                done++;
            end
            begin
                for (int k = 0; k < 25; k++) send_cw(1, 3);
                done++;
            end
            begin
                int n = 0;
                while (done < 2 && n < 5000) begin
                    out_ready = 2'($urandom);
                    idle(1);
                    n++;
                end
            end
        join
        out_ready = 2'b11;
        idle(10);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = '0;
        in_last    = '0;
        out_ready  = 2'b11;
        in_data[0] = '0;
        in_data[1] = '0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        last_acc[0] = 0;
        last_acc[1] = 0;
        test_reset;
        test_single(0);
        test_single(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_stall(0);
        test_stall(1);
        test_reset_mid;
        test_frame(0);
        test_frame(1);
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
